ptw_dcache_arb: RTL and testbench
=================================

# ptw_dcache_arb

Two-to-one arbiter that merges the page-table-walker D$ ports of the dual-MMU wrapper onto a single D$ load port. It sits directly downstream of the wrapper's `req_port_o`/`req_port_o2` outputs and drives their `req_port_i`/`req_port_i2` responses. One full D$ transaction (index phase, tag phase, data return) runs at a time, with round-robin fairness between the two walkers.

## Interface
- No parameters. Payload types are `dcache_req_i_t` (request) and `dcache_req_o_t` (response) from `ariane_pkg`.
- `clk_i` — in — 1 — clock.
- `rst_i` — in — 1 — reset, asynchronous, active-high.
- `ptw0_req_i` — in — `dcache_req_i_t` — request from walker 0.
- `ptw0_rsp_o` — out — `dcache_req_o_t` — response to walker 0.
- `ptw1_req_i` — in — `dcache_req_i_t` — request from walker 1.
- `ptw1_rsp_o` — out — `dcache_req_o_t` — response to walker 1.
- `dcache_req_o` — out — `dcache_req_i_t` — request to the shared D$ port.
- `dcache_rsp_i` — in — `dcache_req_o_t` — response from the shared D$ port.
- `busy_o` — out — 1 — a transaction is owned; high in any state other than IDLE.
- `owner_o` — out — 1 — index of the current owner; 0 when IDLE.

## Operation
- FSM states:
  - IDLE: no owner.
  - WAIT_GNT: owner has an index request outstanding.
  - WAIT_DATA: owner has been granted and is in its tag/data phase.
- Round-robin pointer `last_q` holds the index of the last walker to complete. Reset value is 1, so walker 0 wins the first tie.
- IDLE:
  - Candidate is the requesting walker, judged on `data_req`.
  - If both request, the candidate is `~last_q`.
  - The candidate's request struct is forwarded combinationally to `dcache_req_o`.
  - If `dcache_rsp_i.data_gnt` is high the same cycle, go to WAIT_DATA; otherwise go to WAIT_GNT.
  - Owner is latched as the candidate in either case.
- WAIT_GNT:
  - Owner's struct is forwarded.
  - On `data_gnt`, go to WAIT_DATA.
  - If the owner drops `data_req` without a grant, go to IDLE; `last_q` is not updated.
- WAIT_DATA:
  - Owner's struct (`address_tag`, `tag_valid`, `kill_req`) is forwarded. `data_req` to D$ is forced 0.
  - On `data_rvalid`, go to IDLE and set `last_q` to the owner.
  - On owner `kill_req`, go to IDLE and set `last_q` to the owner. Any `data_rvalid` in that same cycle is still routed to the owner.
- Response routing:
  - `data_gnt` and `data_rvalid` reach only the owner (the candidate while in IDLE). The other walker sees 0.
  - `data_rdata` is broadcast to both walkers.
- When no walker is selected, `dcache_req_o` is all-zero.
- Any `data_rvalid` arriving while IDLE is dropped.
- Async reset at any point returns the FSM to IDLE, clears the owner and sets `last_q` to 1. An in-flight transaction is abandoned and its later `rvalid` is dropped.

## Timing
- Reset values:
  - `busy_o` = 0, `owner_o` = 0, `dcache_req_o` = all-zero.
  - Both response ports = all-zero.
- Request to D$ has zero-cycle latency: the IDLE→D$ path is combinational.
- Grant to walker has zero-cycle latency (combinational pass-through).
- A transaction occupies at least 2 cycles: IDLE with grant, then WAIT_DATA with rvalid.
- After completion, IDLE lasts at least one cycle. No new index request is forwarded in the same cycle as the terminating `rvalid` or kill.
- A waiting walker is served within one transaction of the other walker.
- Registered state: `state_q`, `owner_q`, `last_q`. All other logic is combinational.

## Test plan
- Single request: walker 0 requests, index 0x12; D$ grants in the same cycle; `rvalid` 3 cycles later with rdata 0xDEAD.
  - Walker 0 sees gnt at cycle 0 and rvalid with 0xDEAD at cycle 3.
  - Walker 1 sees gnt = rvalid = 0 throughout.
  - `busy_o` is high during cycles 1–3.
- Simultaneous requests after reset:
  - Walker 0 is served first.
  - Walker 1's request is forwarded on the first IDLE cycle after walker 0's rvalid.
  - A second simultaneous pair is then served walker 0 first again, since `last_q` = 1.
- Grant stall: D$ holds gnt low for 4 cycles.
  - FSM stays in WAIT_GNT with owner fixed.
  - A late request from the other walker is not forwarded.
- Kill in WAIT_DATA: owner 1 raises `kill_req`.
  - `kill_req` reaches D$ in the same cycle.
  - FSM is IDLE next cycle and `last_q` = 1.
- Stray rvalid while IDLE: D$ raises `rvalid` with no transaction owned.
  - Neither walker sees `rvalid`.
- Mid-transaction reset: assert `rst_i` in WAIT_DATA.
  - All outputs are zero immediately.
  - A subsequent `rvalid` is dropped.
  - The next pair of simultaneous requests grants walker 0 first.

Source files
------------

// File: rtl/ptw_dcache_arb.sv
// Round-robin 2:1 arbiter merging two page-table-walker D$ load ports onto one.
// One full transaction (index, tag, data return) is owned at a time.

// Minimal ariane_pkg with just the D$ port payload types, so this file elaborates on its own.
package ariane_pkg;
   typedef struct packed {
      logic [11:0] address_index;
      logic [43:0] address_tag;
      logic [63:0] data_wdata;
      logic        data_req;
      logic        data_we;
      logic [7:0]  data_be;
      logic [1:0]  data_size;
      logic        kill_req;
      logic        tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;
endpackage

module ptw_dcache_arb (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  ariane_pkg::dcache_req_i_t ptw0_req_i,
   output ariane_pkg::dcache_req_o_t ptw0_rsp_o,
   input  ariane_pkg::dcache_req_i_t ptw1_req_i,
   output ariane_pkg::dcache_req_o_t ptw1_rsp_o,
   output ariane_pkg::dcache_req_i_t dcache_req_o,
   input  ariane_pkg::dcache_req_o_t dcache_rsp_i,
   output logic                      busy_o,
   output logic                      owner_o
);
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_DATA} state_t;

   state_t state_q;
   logic   owner_q, last_q;
   logic   sel, sel_valid, gnt, rvalid;
   ariane_pkg::dcache_req_i_t fwd;

   // In IDLE the candidate is picked live; otherwise the latched owner holds the port.
   always_comb begin
      sel       = owner_q;
      sel_valid = 1'b1;
      if (state_q == IDLE) begin
         sel_valid = ptw0_req_i.data_req | ptw1_req_i.data_req;
         sel       = (ptw0_req_i.data_req & ptw1_req_i.data_req) ? ~last_q : ptw1_req_i.data_req;
      end
      fwd = sel ? ptw1_req_i : ptw0_req_i;
   end

   // Outputs are held at zero while reset is asserted so an abandoned walk leaks nothing.
   always_comb begin
      dcache_req_o = '0;
      ptw0_rsp_o   = '0;
      ptw1_rsp_o   = '0;
      gnt          = 1'b0;
      rvalid       = 1'b0;
      if (!rst_i) begin
         if (sel_valid) begin
            dcache_req_o = fwd;
            if (state_q == WAIT_DATA) dcache_req_o.data_req = 1'b0;
         end
         gnt    = sel_valid && (state_q != WAIT_DATA) && dcache_rsp_i.data_gnt;
         rvalid = (state_q != IDLE) && dcache_rsp_i.data_rvalid;
         ptw0_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
         ptw1_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
         ptw0_rsp_o.data_gnt    = gnt & ~sel;
         ptw1_rsp_o.data_gnt    = gnt &  sel;
         ptw0_rsp_o.data_rvalid = rvalid & ~sel;
         ptw1_rsp_o.data_rvalid = rvalid &  sel;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: if (sel_valid) begin
               owner_q <= sel;
               state_q <= dcache_rsp_i.data_gnt ? WAIT_DATA : WAIT_GNT;
            end
            WAIT_GNT: begin
               if (dcache_rsp_i.data_gnt) state_q <= WAIT_DATA;
               else if (!fwd.data_req)    state_q <= IDLE;
            end
            WAIT_DATA: if (dcache_rsp_i.data_rvalid || fwd.kill_req) begin
               state_q <= IDLE;
               last_q  <= owner_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign owner_o = busy_o & owner_q;
endmodule

// File: tb/tb_ptw_dcache_arb.sv
// Directed bench for ptw_dcache_arb: single walk, ties, grant stall, kill,
// stray rvalid and mid-transaction reset, all with hand-computed expectations.
module tb_ptw_dcache_arb;
   import ariane_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   dcache_req_i_t w0, w1, dreq;
   dcache_req_o_t r0, r1, drsp;
   logic          busy, owner;
   int            n_chk = 0, n_fail = 0;

   ptw_dcache_arb dut (
      .clk_i(clk), .rst_i(rst),
      .ptw0_req_i(w0), .ptw0_rsp_o(r0),
      .ptw1_req_i(w1), .ptw1_rsp_o(r1),
      .dcache_req_o(dreq), .dcache_rsp_i(drsp),
      .busy_o(busy), .owner_o(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic dcache_req_i_t idx_req(input logic [11:0] idx);
      dcache_req_i_t r;
      r = '0;
      r.address_index = idx;
      r.data_req = 1'b1;
      r.data_size = 2'd3;
      return r;
   endfunction

   function automatic dcache_req_i_t tag_ph(input logic [43:0] tag, input logic kill);
      dcache_req_i_t r;
      r = '0;
      r.address_tag = tag;
      r.tag_valid = 1'b1;
      r.kill_req = kill;
      return r;
   endfunction

   // Advance to just after the next rising edge; inputs are then driven and sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input dcache_req_i_t a, input dcache_req_i_t b,
                        input logic g, input logic v, input logic [63:0] d);
      w0 = a;
      w1 = b;
      drsp.data_gnt = g;
      drsp.data_rvalid = v;
      drsp.data_rdata = d;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0, '0, 1'b0, 1'b0, 64'h0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      w0 = '0; w1 = '0; drsp = '0;
      #2;
      // reset state
      drive('0, '0, 1'b0, 1'b0, 64'h0);
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_owner", 256'(owner), 256'(0));
      chk("rst_dreq", 256'(dreq), 256'(0));
      chk("rst_r0", 256'(r0), 256'(0));
      chk("rst_r1", 256'(r1), 256'(0));
      tick();
      rst = 1'b0;

      // single request from walker 0
      drive(idx_req(12'h12), '0, 1'b1, 1'b0, 64'h0);
      chk("s_idx", 256'(dreq.address_index), 256'(12'h12));
      chk("s_dreq", 256'(dreq.data_req), 256'(1));
      chk("s_gnt0", 256'(r0.data_gnt), 256'(1));
      chk("s_gnt1", 256'(r1.data_gnt), 256'(0));
      tick();
      drive(tag_ph(44'h55, 1'b0), '0, 1'b0, 1'b0, 64'h0);
      chk("s_busy1", 256'(busy), 256'(1));
      chk("s_tag", 256'(dreq.address_tag), 256'(44'h55));
      chk("s_dreq_off", 256'(dreq.data_req), 256'(0));
      tick();
      drive(tag_ph(44'h55, 1'b0), '0, 1'b0, 1'b0, 64'h0);
      chk("s_busy2", 256'(busy), 256'(1));
      tick();
      drive(tag_ph(44'h55, 1'b0), '0, 1'b0, 1'b1, 64'hDEAD);
      chk("s_busy3", 256'(busy), 256'(1));
      chk("s_rv0", 256'(r0.data_rvalid), 256'(1));
      chk("s_rd0", 256'(r0.data_rdata), 256'(64'hDEAD));
      chk("s_rv1", 256'(r1.data_rvalid), 256'(0));
      chk("s_rd1", 256'(r1.data_rdata), 256'(64'hDEAD));
      tick();
      drive('0, '0, 1'b0, 1'b0, 64'h0);
      chk("s_busy4", 256'(busy), 256'(0));

      // simultaneous requests after reset
      do_reset();
      drive(idx_req(12'hA0), idx_req(12'hB1), 1'b1, 1'b0, 64'h0);
      chk("t_idx0", 256'(dreq.address_index), 256'(12'hA0));
      chk("t_gnt0", 256'(r0.data_gnt), 256'(1));
      chk("t_gnt1", 256'(r1.data_gnt), 256'(0));
      tick();
      drive(tag_ph(44'h1, 1'b0), idx_req(12'hB1), 1'b0, 1'b1, 64'h11);
      chk("t_rv0", 256'(r0.data_rvalid), 256'(1));
      chk("t_rv1", 256'(r1.data_rvalid), 256'(0));
      chk("t_hold", 256'(dreq.data_req), 256'(0));
      tick();
      drive('0, idx_req(12'hB1), 1'b1, 1'b0, 64'h0);
      chk("t_idx1", 256'(dreq.address_index), 256'(12'hB1));
      chk("t_gnt1b", 256'(r1.data_gnt), 256'(1));
      chk("t_gnt0b", 256'(r0.data_gnt), 256'(0));
      tick();
      drive('0, tag_ph(44'h2, 1'b0), 1'b0, 1'b1, 64'h22);
      chk("t_own1", 256'(owner), 256'(1));
      chk("t_rv1b", 256'(r1.data_rvalid), 256'(1));
      tick();
      drive(idx_req(12'hA0), idx_req(12'hB1), 1'b1, 1'b0, 64'h0);
      chk("t_idx2", 256'(dreq.address_index), 256'(12'hA0));
      chk("t_gnt0c", 256'(r0.data_gnt), 256'(1));
      tick();
      drive(tag_ph(44'h3, 1'b0), '0, 1'b0, 1'b1, 64'h33);
      chk("t_rv0c", 256'(r0.data_rvalid), 256'(1));
      tick();

      // grant stall then kill in WAIT_DATA (last_q is 0 here)
      drive('0, idx_req(12'h33), 1'b0, 1'b0, 64'h0);
      chk("g_idx", 256'(dreq.address_index), 256'(12'h33));
      chk("g_gnt1", 256'(r1.data_gnt), 256'(0));
      tick();
      drive('0, idx_req(12'h33), 1'b0, 1'b0, 64'h0);
      chk("g_busy", 256'(busy), 256'(1));
      chk("g_own", 256'(owner), 256'(1));
      for (int i = 0; i < 2; i++) begin
         tick();
         drive(idx_req(12'h44), idx_req(12'h33), 1'b0, 1'b0, 64'h0);
         chk("g_hold_idx", 256'(dreq.address_index), 256'(12'h33));
         chk("g_hold_own", 256'(owner), 256'(1));
         chk("g_nogrant0", 256'(r0.data_gnt), 256'(0));
      end
      tick();
      drive(idx_req(12'h44), idx_req(12'h33), 1'b1, 1'b0, 64'h0);
      chk("g_gnt1", 256'(r1.data_gnt), 256'(1));
      chk("g_gnt0", 256'(r0.data_gnt), 256'(0));
      tick();
      drive(idx_req(12'h44), tag_ph(44'h77, 1'b1), 1'b0, 1'b0, 64'h0);
      chk("k_kill", 256'(dreq.kill_req), 256'(1));
      chk("k_noreq", 256'(dreq.data_req), 256'(0));
      tick();
      drive('0, '0, 1'b0, 1'b0, 64'h0);
      chk("k_idle", 256'(busy), 256'(0));
      tick();
      drive(idx_req(12'h44), idx_req(12'h33), 1'b0, 1'b0, 64'h0);
      chk("k_last", 256'(dreq.address_index), 256'(12'h44));
      tick();
      drive('0, '0, 1'b0, 1'b0, 64'h0);
      chk("d_waitgnt", 256'(busy), 256'(1));
      tick();
      drive('0, '0, 1'b0, 1'b0, 64'h0);
      chk("d_abandon", 256'(busy), 256'(0));

      // stray rvalid while IDLE
      drive('0, '0, 1'b0, 1'b1, 64'h99);
      chk("x_rv0", 256'(r0.data_rvalid), 256'(0));
      chk("x_rv1", 256'(r1.data_rvalid), 256'(0));
      tick();
      drive(idx_req(12'h5), '0, 1'b0, 1'b1, 64'h99);
      chk("x_rv0_cand", 256'(r0.data_rvalid), 256'(0));
      tick();
      drive('0, '0, 1'b0, 1'b0, 64'h0);
      tick();

      // mid-transaction reset
      drive(idx_req(12'h12), '0, 1'b1, 1'b0, 64'h0);
      tick();
      drive(tag_ph(44'h9, 1'b0), '0, 1'b0, 1'b0, 64'hBEEF);
      chk("m_busy_pre", 256'(busy), 256'(1));
      rst = 1'b1;
      #1;
      chk("m_busy", 256'(busy), 256'(0));
      chk("m_owner", 256'(owner), 256'(0));
      chk("m_dreq", 256'(dreq), 256'(0));
      chk("m_r0", 256'(r0), 256'(0));
      chk("m_r1", 256'(r1), 256'(0));
      tick();
      rst = 1'b0;
      drive('0, '0, 1'b0, 1'b1, 64'hBEEF);
      chk("m_stray", 256'(r0.data_rvalid), 256'(0));
      tick();
      drive(idx_req(12'hA0), idx_req(12'hB1), 1'b1, 1'b0, 64'h0);
      chk("m_idx", 256'(dreq.address_index), 256'(12'hA0));
      chk("m_gnt0", 256'(r0.data_gnt), 256'(1));
      chk("m_gnt1", 256'(r1.data_gnt), 256'(0));
      tick();
      drive('0, '0, 1'b0, 1'b0, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
